// File: rtl/mac_tx_arbiter_pkg.sv
// Shared constants and helpers for the MAC transmit arbiter.
package mac_tx_arbiter_pkg;

    localparam int MAC_ADDR_W = 48;

    // Index width for a source count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_select
    import mac_tx_arbiter_pkg::*;
#(
    parameter int  NUM_INPUTS = 4,
    localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [IDX_W-1:0]      winner,
    output logic                  any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        // Scan from the farthest offset down so the closest requester is written last.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_INPUTS;
            if (req[idx]) begin
                winner    = idx[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin arbiter merging several AXI-stream byte sources into one MAC transmitter.
module mac_tx_arbiter
    import mac_tx_arbiter_pkg::*;
#(
    parameter int  NUM_INPUTS     = 4,
    parameter int  AXI_DATA_WIDTH = 8,
    localparam int IDX_W          = idx_width(NUM_INPUTS)
) (
    input  logic                                       Clk,
    input  logic                                       Rst,
    input  logic [NUM_INPUTS-1:0]                      S_axis_valid,
    input  logic [NUM_INPUTS-1:0][AXI_DATA_WIDTH-1:0]  S_axis_data,
    input  logic [NUM_INPUTS-1:0]                      S_axis_last,
    output logic [NUM_INPUTS-1:0]                      S_axis_ready,
    input  logic [NUM_INPUTS-1:0][MAC_ADDR_W-1:0]      S_dest_mac,
    output logic                                       M_axis_valid,
    output logic [AXI_DATA_WIDTH-1:0]                  M_axis_data,
    output logic                                       M_axis_last,
    input  logic                                       M_axis_ready,
    output logic [MAC_ADDR_W-1:0]                      Dest_mac,
    output logic [IDX_W-1:0]                           Grant_index,
    output logic                                       Busy
);

    typedef enum logic {S_IDLE, S_PASS} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             beat_last;

    rr_select #(
        .NUM_INPUTS(NUM_INPUTS)
    ) u_rr_select (
        .req      (S_axis_valid),
        .ptr      (ptr),
        .winner   (winner),
        .any_valid(any_valid)
    );

    assign ptr_next  = (Grant_index == IDX_W'(NUM_INPUTS - 1)) ? '0 : Grant_index + IDX_W'(1);
    assign beat_last = M_axis_valid & M_axis_ready & M_axis_last;

    // Pass-through path: only the granted source sees the sink's ready.
    always_comb begin
        M_axis_valid = 1'b0;
        M_axis_data  = '0;
        M_axis_last  = 1'b0;
        S_axis_ready = '0;
        if (state == S_PASS) begin
            M_axis_valid              = S_axis_valid[Grant_index];
            M_axis_data               = S_axis_data[Grant_index];
            M_axis_last               = S_axis_last[Grant_index];
            S_axis_ready[Grant_index] = M_axis_ready;
        end
    end

    // Grant is latched for the whole packet; re-arbitration only after the last beat.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            Grant_index <= '0;
            Dest_mac    <= '0;
            Busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        Grant_index <= winner;
                        Dest_mac    <= S_dest_mac[winner];
                        Busy        <= 1'b1;
                        state       <= S_PASS;
                    end
                end
                S_PASS: begin
                    if (beat_last) begin
                        ptr   <= ptr_next;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
